// File: rtl/ant_pkg.sv
// Shared types and helpers for the ant forager agent.
// Provides the FSM state enum, compass direction constants, per-direction
// step lookups, a wrap-aware Manhattan distance and the LFSR constants.
package ant_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEPOSIT = 2'd1,
    MOVED   = 2'd2
  } ant_state_t;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_S = 3'd4;
  localparam logic [2:0] DIR_W = 3'd6;

  localparam logic [15:0] LFSR_RESET = 16'hACE1;
  // Right-shifting Galois form of taps 16,14,13,11
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  // X step for a heading (E side positive)
  function automatic int dir_dx(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: return 1;
      3'd5, 3'd6, 3'd7: return -1;
      default:          return 0;
    endcase
  endfunction

  // Y step for a heading (N is Y-1)
  function automatic int dir_dy(input logic [2:0] d);
    case (d)
      3'd7, 3'd0, 3'd1: return -1;
      3'd3, 3'd4, 3'd5: return 1;
      default:          return 0;
    endcase
  endfunction

  // One-axis distance, taking the short way round when wrapping
  function automatic int axis_dist(input int a, input int b, input int g, input bit wrap);
    int d;
    d = (a > b) ? (a - b) : (b - a);
    if (wrap && ((g - d) < d)) d = g - d;
    return d;
  endfunction

  function automatic int manhattan(input int ax, input int ay, input int bx, input int by,
                                   input int gw, input int gh, input bit wrap);
    return axis_dist(ax, bx, gw, wrap) + axis_dist(ay, by, gh, wrap);
  endfunction

endpackage

// File: rtl/ant_forager_lfsr16.sv
// 16-bit free-running Galois LFSR with seed load (zero seed maps to ACE1).
// Ports: newLocClock/RESET, i_load + i_seed load, o_lfsr current state.
module ant_lfsr16
  import ant_pkg::*;
(
  input  logic        newLocClock,
  input  logic        RESET,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  always_ff @(posedge newLocClock or posedge RESET) begin
    if (RESET) begin
      r_lfsr <= LFSR_RESET;
    end else if (i_load) begin
      r_lfsr <= (i_seed == 16'h0000) ? LFSR_RESET : i_seed;
    end else begin
      r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/ant_forager.sv
// Chemotaxis ant agent: holds pose, carry state and nest location, moves one
// cell per granted slot and requests a pheromone deposit after loaded moves.
// Ports: init_* load bus, onSugar/surrounding_signals sensing, moveNow slot,
// global_writing_flag rearm, pose/carry outputs, dep_* valid/ready request.
module ant_forager
  import ant_pkg::*;
#(
  parameter int unsigned X_BITS       = 8,
  parameter int unsigned Y_BITS       = 8,
  parameter int unsigned GRID_W       = 256,
  parameter int unsigned GRID_H       = 256,
  parameter int unsigned SIGNAL_BITS  = 8,
  parameter int unsigned SENSE_THRESH = 1,
  parameter int unsigned WIGGLE_EN    = 1,
  parameter int unsigned WIGGLE_BITS  = 2,
  parameter int unsigned EDGE_MODE    = 0,
  parameter logic [SIGNAL_BITS-1:0] DEPOSIT_AMT = SIGNAL_BITS'(16)
) (
  input  logic                     newLocClock,
  input  logic                     RESET,
  input  logic                     init_valid,
  input  logic [X_BITS-1:0]        init_X,
  input  logic [Y_BITS-1:0]        init_Y,
  input  logic [2:0]               init_dir,
  input  logic [X_BITS-1:0]        init_colony_X,
  input  logic [Y_BITS-1:0]        init_colony_Y,
  input  logic [15:0]              init_seed,
  input  logic                     onSugar,
  input  logic [8*SIGNAL_BITS-1:0] surrounding_signals,
  input  logic                     moveNow,
  input  logic                     global_writing_flag,
  output logic [X_BITS-1:0]        X,
  output logic [Y_BITS-1:0]        Y,
  output logic [2:0]               dir,
  output logic                     mouthFull,
  output logic                     collecting_sugar,
  output logic                     dropping_sugar,
  output logic                     dep_valid,
  input  logic                     dep_ready,
  output logic [X_BITS-1:0]        dep_X,
  output logic [Y_BITS-1:0]        dep_Y,
  output logic [SIGNAL_BITS-1:0]   dep_amount,
  output logic                     moved
);

  localparam bit WRAP = (EDGE_MODE == 0);

  ant_state_t r_state, w_state_nxt;
  logic [X_BITS-1:0] r_x, r_col_x, r_dep_x, w_x_nxt;
  logic [Y_BITS-1:0] r_y, r_col_y, r_dep_y, w_y_nxt;
  logic [2:0]  r_dir, w_dir_l, w_dir_r, w_dir_dec, w_dir_nxt;
  logic        r_mouth, r_collect, r_drop;
  logic        w_pick, w_drop, w_mouth_nxt, w_move, w_off_grid, w_wiggle;
  logic [15:0] w_lfsr;
  logic        w_unused_lfsr;
  logic [SIGNAL_BITS-1:0] w_sig [8];
  int w_fx, w_fy, w_lx, w_ly, w_rx, w_ry;
  int w_df, w_dl, w_dr, w_best, w_sf, w_sl, w_sr;
  logic [2:0] w_best_dir;

  ant_lfsr16 u_lfsr (
    .newLocClock (newLocClock),
    .RESET       (RESET),
    .i_load      (init_valid),
    .i_seed      (init_seed),
    .o_lfsr      (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr;

  // Neighbour coordinate with toroidal wrap applied when enabled
  function automatic int wrap_c(input int v, input int g);
    if (WRAP) begin
      if (v < 0)  return v + g;
      if (v >= g) return v - g;
    end
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < 8; i++) w_sig[i] = surrounding_signals[i*SIGNAL_BITS +: SIGNAL_BITS];
  end

  // Heading decision and pose update candidate
  always_comb begin
    w_dir_l     = r_dir - 3'd1;
    w_dir_r     = r_dir + 3'd1;
    w_fx        = wrap_c(int'(r_x) + dir_dx(r_dir),   int'(GRID_W));
    w_fy        = wrap_c(int'(r_y) + dir_dy(r_dir),   int'(GRID_H));
    w_lx        = wrap_c(int'(r_x) + dir_dx(w_dir_l), int'(GRID_W));
    w_ly        = wrap_c(int'(r_y) + dir_dy(w_dir_l), int'(GRID_H));
    w_rx        = wrap_c(int'(r_x) + dir_dx(w_dir_r), int'(GRID_W));
    w_ry        = wrap_c(int'(r_y) + dir_dy(w_dir_r), int'(GRID_H));
    w_df        = manhattan(w_fx, w_fy, int'(r_col_x), int'(r_col_y), int'(GRID_W), int'(GRID_H), WRAP);
    w_dl        = manhattan(w_lx, w_ly, int'(r_col_x), int'(r_col_y), int'(GRID_W), int'(GRID_H), WRAP);
    w_dr        = manhattan(w_rx, w_ry, int'(r_col_x), int'(r_col_y), int'(GRID_W), int'(GRID_H), WRAP);
    w_sf        = int'(w_sig[r_dir]);
    w_sl        = int'(w_sig[w_dir_l]);
    w_sr        = int'(w_sig[w_dir_r]);
    w_best      = w_dl;
    w_best_dir  = w_dir_l;
    w_dir_dec   = r_dir;
    w_pick      = 1'b0;
    w_drop      = 1'b0;
    w_mouth_nxt = r_mouth;

    // Left wins a distance tie
    if (w_dr < w_dl) begin
      w_best     = w_dr;
      w_best_dir = w_dir_r;
    end

    if (r_mouth && (r_x == r_col_x) && (r_y == r_col_y)) begin
      w_drop      = 1'b1;
      w_mouth_nxt = 1'b0;
      w_dir_dec   = r_dir + 3'd4;
    end else if (r_mouth) begin
      if ((w_df - w_best) >= int'(SENSE_THRESH)) w_dir_dec = w_best_dir;
    end else if (onSugar) begin
      w_pick      = 1'b1;
      w_mouth_nxt = 1'b1;
      w_dir_dec   = r_dir + 3'd4;
    end else if (((w_sr - w_sf) >= int'(SENSE_THRESH)) && (w_sr > w_sl)) begin
      w_dir_dec = w_dir_r;
    end else if ((w_sl - w_sf) >= int'(SENSE_THRESH)) begin
      w_dir_dec = w_dir_l;
    end

    w_wiggle  = (WIGGLE_EN != 0) && (w_lfsr[WIGGLE_BITS-1:0] == '0);
    w_dir_nxt = w_wiggle ? (w_dir_dec + (w_lfsr[15] ? 3'd1 : 3'd7)) : w_dir_dec;

    // Reflect: bounce in place, overriding the steering decision
    w_off_grid = !WRAP && ((w_fx < 0) || (w_fx >= int'(GRID_W)) ||
                           (w_fy < 0) || (w_fy >= int'(GRID_H)));
    if (w_off_grid) begin
      w_x_nxt   = r_x;
      w_y_nxt   = r_y;
      w_dir_nxt = r_dir + 3'd4;
    end else begin
      w_x_nxt = X_BITS'(w_fx);
      w_y_nxt = Y_BITS'(w_fy);
    end
  end

  assign w_move = (r_state == IDLE) && moveNow && !init_valid;

  // FSM state register
  always_ff @(posedge newLocClock or posedge RESET) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (moveNow) w_state_nxt = (r_mouth && !w_drop) ? DEPOSIT : MOVED;
      DEPOSIT: if (dep_ready) w_state_nxt = MOVED;
      MOVED:   if (global_writing_flag) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (init_valid) w_state_nxt = IDLE;
  end

  // Pose, carry, nest and deposit-cell registers
  always_ff @(posedge newLocClock or posedge RESET) begin
    if (RESET) begin
      r_x       <= '0;
      r_y       <= '0;
      r_dir     <= DIR_N;
      r_col_x   <= '0;
      r_col_y   <= '0;
      r_mouth   <= 1'b0;
      r_collect <= 1'b0;
      r_drop    <= 1'b0;
      r_dep_x   <= '0;
      r_dep_y   <= '0;
    end else begin
      r_collect <= 1'b0;
      r_drop    <= 1'b0;
      if (init_valid) begin
        r_x     <= init_X;
        r_y     <= init_Y;
        r_dir   <= init_dir;
        r_col_x <= init_colony_X;
        r_col_y <= init_colony_Y;
        r_mouth <= 1'b0;
      end else if (w_move) begin
        r_x       <= w_x_nxt;
        r_y       <= w_y_nxt;
        r_dir     <= w_dir_nxt;
        r_mouth   <= w_mouth_nxt;
        r_collect <= w_pick;
        r_drop    <= w_drop;
        r_dep_x   <= r_x;
        r_dep_y   <= r_y;
      end
    end
  end

  assign X                = r_x;
  assign Y                = r_y;
  assign dir              = r_dir;
  assign mouthFull        = r_mouth;
  assign collecting_sugar = r_collect;
  assign dropping_sugar   = r_drop;
  assign dep_valid        = (r_state == DEPOSIT);
  assign dep_X            = r_dep_x;
  assign dep_Y            = r_dep_y;
  assign dep_amount       = DEPOSIT_AMT;
  assign moved            = (r_state != IDLE);

endmodule

// File: tb/tb_ant_forager.sv
// Directed bench: four ant instances share stimulus, each built with the
// parameters a scenario needs (main, wrap on 16-wide grid, reflect, wiggle).
module tb_ant_forager;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_valid;
  logic [7:0]  init_x, init_y, init_cx, init_cy;
  logic [2:0]  init_dir;
  logic [15:0] init_seed;
  logic        on_sugar;
  logic [63:0] sig;
  logic        move_now, gwf, dep_ready;

  logic [7:0] o_x [4];
  logic [7:0] o_y [4];
  logic [7:0] o_depx [4];
  logic [7:0] o_depy [4];
  logic [7:0] o_amt [4];
  logic [2:0] o_dir [4];
  logic       o_mouth [4];
  logic       o_col [4];
  logic       o_drp [4];
  logic       o_dv [4];
  logic       o_mv [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

`define ANT_INST(NAME, IDX, GW, ST, WE, WB, EM) \
  ant_forager #(.GRID_W(GW), .SENSE_THRESH(ST), .WIGGLE_EN(WE), .WIGGLE_BITS(WB), .EDGE_MODE(EM)) NAME ( \
    .newLocClock(clk), .RESET(rst), .init_valid(init_valid), .init_X(init_x), .init_Y(init_y), \
    .init_dir(init_dir), .init_colony_X(init_cx), .init_colony_Y(init_cy), .init_seed(init_seed), \
    .onSugar(on_sugar), .surrounding_signals(sig), .moveNow(move_now), .global_writing_flag(gwf), \
    .X(o_x[IDX]), .Y(o_y[IDX]), .dir(o_dir[IDX]), .mouthFull(o_mouth[IDX]), \
    .collecting_sugar(o_col[IDX]), .dropping_sugar(o_drp[IDX]), .dep_valid(o_dv[IDX]), \
    .dep_ready(dep_ready), .dep_X(o_depx[IDX]), .dep_Y(o_depy[IDX]), .dep_amount(o_amt[IDX]), \
    .moved(o_mv[IDX]));

  `ANT_INST(u_main, 0, 256, 3, 0, 2, 0)
  `ANT_INST(u_wrap, 1, 16,  1, 0, 2, 0)
  `ANT_INST(u_refl, 2, 16,  1, 0, 2, 1)
  `ANT_INST(u_wig,  3, 256, 1, 1, 1, 0)

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [7:0] x, input logic [7:0] y, input logic [2:0] d,
                         input logic [7:0] cx, input logic [7:0] cy, input logic [15:0] seed);
    init_x = x; init_y = y; init_dir = d; init_cx = cx; init_cy = cy; init_seed = seed;
    init_valid = 1'b1;
    tick();
    init_valid = 1'b0;
  endtask

  task automatic do_move();
    move_now = 1'b1;
    tick();
    move_now = 1'b0;
  endtask

  task automatic do_rearm();
    gwf = 1'b1;
    tick();
    gwf = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({o_x[0], o_y[0], o_dir[0], o_mouth[0], o_col[0], o_drp[0], o_dv[0], o_mv[0]} !== 24'h0) begin
      failures++;
      $display("FAIL reset: x=%0d y=%0d dir=%0d mouth=%b dv=%b moved=%b, required all 0",
               o_x[0], o_y[0], o_dir[0], o_mouth[0], o_dv[0], o_mv[0]);
    end
  endtask

  task automatic test_basic_move();
    do_init(8'd10, 8'd10, 3'd2, 8'd10, 8'd10, 16'h0001);
    do_move();
    checks++;
    if ({o_x[0], o_y[0], o_dir[0], o_mv[0]} !== {8'd11, 8'd10, 3'd2, 1'b1}) begin
      failures++;
      $display("FAIL basic_move: x=%0d y=%0d dir=%0d moved=%b, required 11 10 2 1",
               o_x[0], o_y[0], o_dir[0], o_mv[0]);
    end
    do_rearm();
    checks++;
    if (o_mv[0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_rearm: moved=%b, required 0", o_mv[0]);
    end
  endtask

  task automatic test_sense_thresh();
    do_init(8'd10, 8'd10, 3'd2, 8'd0, 8'd0, 16'h0001);
    sig = 64'h0;
    sig[23:16] = 8'd5;
    sig[31:24] = 8'd7;
    do_move();
    checks++;
    if ({o_x[0], o_dir[0]} !== {8'd11, 3'd2}) begin
      failures++;
      $display("FAIL sense_below: x=%0d dir=%0d, required 11 2", o_x[0], o_dir[0]);
    end
    do_rearm();
    sig[31:24] = 8'd8;
    do_move();
    checks++;
    if ({o_x[0], o_dir[0]} !== {8'd12, 3'd3}) begin
      failures++;
      $display("FAIL sense_turn: x=%0d dir=%0d, required 12 3", o_x[0], o_dir[0]);
    end
    do_rearm();
    sig = 64'h0;
  endtask

  task automatic test_pickup_deposit();
    do_init(8'd20, 8'd20, 3'd0, 8'd10, 8'd10, 16'h0001);
    on_sugar = 1'b1;
    do_move();
    on_sugar = 1'b0;
    checks++;
    if ({o_mouth[0], o_col[0], o_x[0], o_y[0], o_dir[0], o_dv[0]} !== {1'b1, 1'b1, 8'd20, 8'd19, 3'd4, 1'b0}) begin
      failures++;
      $display("FAIL pickup: mouth=%b col=%b x=%0d y=%0d dir=%0d dv=%b, required 1 1 20 19 4 0",
               o_mouth[0], o_col[0], o_x[0], o_y[0], o_dir[0], o_dv[0]);
    end
    tick();
    checks++;
    if (o_col[0] !== 1'b0) begin
      failures++;
      $display("FAIL pickup_pulse: col=%b, required 0", o_col[0]);
    end
    do_rearm();
    do_move();
    checks++;
    if ({o_dv[0], o_depx[0], o_depy[0], o_amt[0], o_mv[0], o_y[0]} !== {1'b1, 8'd20, 8'd19, 8'd16, 1'b1, 8'd20}) begin
      failures++;
      $display("FAIL deposit: dv=%b dep=(%0d,%0d) amt=%0d moved=%b y=%0d, required 1 (20,19) 16 1 20",
               o_dv[0], o_depx[0], o_depy[0], o_amt[0], o_mv[0], o_y[0]);
    end
    dep_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({o_dv[0], o_depx[0], o_depy[0], o_amt[0]} !== {1'b1, 8'd20, 8'd19, 8'd16}) begin
        failures++;
        $display("FAIL deposit_hold[%0d]: dv=%b dep=(%0d,%0d) amt=%0d, required 1 (20,19) 16",
                 i, o_dv[0], o_depx[0], o_depy[0], o_amt[0]);
      end
    end
    dep_ready = 1'b1;
    tick();
    dep_ready = 1'b0;
    checks++;
    if ({o_dv[0], o_mv[0]} !== 2'b01) begin
      failures++;
      $display("FAIL deposit_accept: dv=%b moved=%b, required 0 1", o_dv[0], o_mv[0]);
    end
    do_rearm();
  endtask

  task automatic test_drop_at_nest();
    do_init(8'd9, 8'd10, 3'd2, 8'd10, 8'd10, 16'h0001);
    on_sugar = 1'b1;
    do_move();
    on_sugar = 1'b0;
    checks++;
    if ({o_x[0], o_dir[0], o_mouth[0], o_dv[0]} !== {8'd10, 3'd6, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL drop_setup: x=%0d dir=%0d mouth=%b dv=%b, required 10 6 1 0",
               o_x[0], o_dir[0], o_mouth[0], o_dv[0]);
    end
    do_rearm();
    do_move();
    checks++;
    if ({o_drp[0], o_mouth[0], o_x[0], o_y[0], o_dir[0], o_dv[0], o_mv[0]} !== {1'b1, 1'b0, 8'd9, 8'd10, 3'd2, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL drop: drp=%b mouth=%b x=%0d y=%0d dir=%0d dv=%b moved=%b, required 1 0 9 10 2 0 1",
               o_drp[0], o_mouth[0], o_x[0], o_y[0], o_dir[0], o_dv[0], o_mv[0]);
    end
    tick();
    checks++;
    if ({o_drp[0], o_dv[0]} !== 2'b00) begin
      failures++;
      $display("FAIL drop_pulse: drp=%b dv=%b, required 0 0", o_drp[0], o_dv[0]);
    end
    do_rearm();
  endtask

  task automatic test_grid_edge();
    do_init(8'd15, 8'd5, 3'd2, 8'd0, 8'd0, 16'h0001);
    do_move();
    checks++;
    if ({o_x[1], o_y[1], o_dir[1]} !== {8'd0, 8'd5, 3'd2}) begin
      failures++;
      $display("FAIL edge_wrap: x=%0d y=%0d dir=%0d, required 0 5 2", o_x[1], o_y[1], o_dir[1]);
    end
    checks++;
    if ({o_x[2], o_y[2], o_dir[2]} !== {8'd15, 8'd5, 3'd6}) begin
      failures++;
      $display("FAIL edge_reflect: x=%0d y=%0d dir=%0d, required 15 5 6", o_x[2], o_y[2], o_dir[2]);
    end
    do_rearm();
  endtask

  task automatic test_init_abort();
    do_init(8'd20, 8'd20, 3'd0, 8'd10, 8'd10, 16'h0001);
    on_sugar = 1'b1;
    do_move();
    on_sugar = 1'b0;
    do_rearm();
    do_move();
    tick();
    checks++;
    if (o_dv[0] !== 1'b1) begin
      failures++;
      $display("FAIL abort_setup: dv=%b, required 1", o_dv[0]);
    end
    do_init(8'd30, 8'd30, 3'd2, 8'd10, 8'd10, 16'h0001);
    checks++;
    if ({o_dv[0], o_mv[0], o_mouth[0], o_x[0]} !== {1'b0, 1'b0, 1'b0, 8'd30}) begin
      failures++;
      $display("FAIL abort: dv=%b moved=%b mouth=%b x=%0d, required 0 0 0 30",
               o_dv[0], o_mv[0], o_mouth[0], o_x[0]);
    end
    do_move();
    checks++;
    if ({o_dv[0], o_mv[0], o_x[0]} !== {1'b0, 1'b1, 8'd31}) begin
      failures++;
      $display("FAIL abort_rearm: dv=%b moved=%b x=%0d, required 0 1 31", o_dv[0], o_mv[0], o_x[0]);
    end
    do_rearm();
  endtask

  task automatic test_wiggle();
    int n_wig;
    int n_still;
    logic [2:0] prev_w, prev_m;
    n_wig = 0;
    n_still = 0;
    sig = 64'h0;
    on_sugar = 1'b0;
    do_init(8'd100, 8'd100, 3'd2, 8'd200, 8'd200, 16'h0000);
    for (int i = 0; i < 1000; i++) begin
      prev_w = o_dir[3];
      prev_m = o_dir[0];
      do_move();
      if (o_dir[3] != prev_w) n_wig++;
      if (o_dir[0] != prev_m) n_still++;
      do_rearm();
    end
    checks++;
    if (n_wig < 450 || n_wig > 550) begin
      failures++;
      $display("FAIL wiggle_rate: count=%0d, required 450..550", n_wig);
    end
    checks++;
    if (n_still != 0) begin
      failures++;
      $display("FAIL wiggle_disabled: turns=%0d, required 0", n_still);
    end
  endtask

  initial begin
    rst = 1'b1; init_valid = 1'b0; init_x = '0; init_y = '0; init_dir = '0;
    init_cx = '0; init_cy = '0; init_seed = '0; on_sugar = 1'b0; sig = '0;
    move_now = 1'b0; gwf = 1'b0; dep_ready = 1'b0;
    test_reset();
    test_basic_move();
    test_sense_thresh();
    test_pickup_deposit();
    test_drop_at_nest();
    test_grid_edge();
    test_init_abort();
    test_wiggle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
